// File: rtl/fcvt96_arbiter.sv
// rtl/fcvt96_arbiter.sv - round-robin arbiter/sequencer sharing one f2i96 converter among NREQ requesters
// Optional sticky per-requester overflow flags when FCVT96_OVF_STICKY_EN is defined.
module fcvt96_arbiter #(
    parameter int NREQ = 4,
    parameter int WID  = 96,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*WID-1:0]  req_data,
    output logic                 cvt_ce,
    output logic                 cvt_op,
    output logic [WID-1:0]       cvt_i,
    input  logic [WID-1:0]       cvt_o,
    input  logic                 cvt_ovf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WID-1:0]       rsp_data,
    output logic                 rsp_ovf,
    output logic [IDW-1:0]       rsp_id,
    output logic [NREQ-1:0]      ovf_sticky,
    input  logic [NREQ-1:0]      ovf_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_RSP   = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] last;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx_v;
    int             idx;
    logic           any_req;
    logic           grant_en;
    logic           grant;

    logic           op_q;
    logic [WID-1:0] data_q;
    logic [IDW-1:0] id_q;
    logic           ovf_q;

    // Scan from last+NREQ down to last+1 so the nearest successor of last wins.
    always_comb begin
        win     = last;
        any_req = 1'b0;
        idx     = 0;
        idx_v   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx   = (int'(last) + i) % NREQ;
            idx_v = IDW'(idx);
            if (req_valid[idx_v]) begin
                win     = idx_v;
                any_req = 1'b1;
            end
        end
    end

    // The converter is free in IDLE, and in RSP once the response is consumed.
    assign grant_en  = (state == S_IDLE) || ((state == S_RSP) && rsp_ready);
    assign grant     = grant_en && any_req;
    assign req_ready = grant ? (NREQ'(1) << win) : '0;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (grant) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_CAPT;
            S_CAPT:  state_nx = S_RSP;
            S_RSP: begin
                if (rsp_ready) state_nx = grant ? S_ISSUE : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign cvt_ce    = (state == S_ISSUE);
    assign rsp_valid = (state == S_RSP);
    assign cvt_op    = op_q;
    assign cvt_i     = data_q;

    // Operands stay put through CAPT: the converter's sign fix-up reads live op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            last     <= IDW'(NREQ - 1);
            op_q     <= 1'b0;
            data_q   <= '0;
            id_q     <= '0;
            ovf_q    <= 1'b0;
            rsp_data <= '0;
            rsp_ovf  <= 1'b0;
            rsp_id   <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                op_q   <= req_op[win];
                data_q <= req_data[int'(win)*WID +: WID];
                id_q   <= win;
                last   <= win;
            end
            if (state == S_ISSUE) ovf_q <= cvt_ovf;
            if (state == S_CAPT) begin
                rsp_data <= cvt_o;
                rsp_ovf  <= ovf_q;
                rsp_id   <= id_q;
            end
        end
    end

`ifdef FCVT96_OVF_STICKY_EN
    logic [NREQ-1:0] sticky_q;
    logic [NREQ-1:0] sticky_set;

    always_comb begin
        sticky_set = '0;
        if (rsp_valid && rsp_ready && rsp_ovf) sticky_set = NREQ'(1) << rsp_id;
    end

    // Set is OR-ed after the clear so a coincident set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) sticky_q <= '0;
        else        sticky_q <= (sticky_q & ~ovf_clr) | sticky_set;
    end

    assign ovf_sticky = sticky_q;
`else
    logic unused_clr;
    assign unused_clr = ^ovf_clr;
    assign ovf_sticky = '0;
`endif

endmodule

// File: tb/tb_fcvt96_arbiter.sv
// tb/tb_fcvt96_arbiter.sv - randomized self-checking bench for fcvt96_arbiter with a behavioural f2i96 stand-in
module tb_fcvt96_arbiter;
    localparam int NREQ = 4;
    localparam int WID  = 96;
    localparam int IDW  = 2;
    localparam int BIAS = 16383;
`ifdef FCVT96_OVF_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam logic [95:0] SMAX = {1'b0, {95{1'b1}}};
    localparam logic [95:0] SMIN = {1'b1, 95'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_op;
    logic [NREQ*WID-1:0] req_data;
    logic                cvt_ce, cvt_op, cvt_ovf;
    logic [WID-1:0]      cvt_i, cvt_o;
    logic                rsp_valid, rsp_ready, rsp_ovf;
    logic [WID-1:0]      rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic [NREQ-1:0]     ovf_sticky, ovf_clr;

    fcvt96_arbiter #(.NREQ(NREQ), .WID(WID)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .cvt_ce(cvt_ce), .cvt_op(cvt_op), .cvt_i(cvt_i), .cvt_o(cvt_o), .cvt_ovf(cvt_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
        .rsp_id(rsp_id), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    // Converter stand-in: sign/exp15/frac80 format, magnitude registered on ce, sign applied from live op
    int          d_s;
    logic [80:0] d_m81;
    logic [95:0] d_mag;
    logic        d_big, d_huge;
    logic [95:0] c_mag = '0;
    logic        c_neg = 1'b0, c_big = 1'b0, c_huge = 1'b0;

    always_comb begin
        d_s    = int'(cvt_i[94:80]) - BIAS;
        d_m81  = {1'b1, cvt_i[79:0]};
        d_big  = d_s >= 95;
        d_huge = d_s >= 96;
        d_mag  = '0;
        if (d_s >= 0 && d_s <= 80) d_mag = 96'(d_m81 >> (80 - d_s));
        else if (d_s > 80 && d_s < 96) d_mag = 96'(d_m81) << (d_s - 80);
        cvt_ovf = cvt_op ? d_big : d_huge;
        if (cvt_op) cvt_o = c_big ? (c_neg ? SMIN : SMAX) : (c_neg ? -c_mag : c_mag);
        else        cvt_o = c_huge ? '1 : c_mag;
    end

    always @(posedge clk) begin
        if (cvt_ce) begin
            c_mag  <= d_mag;
            c_neg  <= cvt_i[95];
            c_big  <= d_big;
            c_huge <= d_huge;
        end
    end

    // Requester operands and their expected results, derived from the integer value that was encoded
    logic [95:0] r_data[NREQ];
    bit          r_op[NREQ];
    logic [95:0] r_exp[NREQ];
    bit          r_eovf[NREQ];

    always_comb begin
        req_data = '0;
        req_op   = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_data[k*WID +: WID] = r_data[k];
            req_op[k]              = r_op[k];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] enc(input bit neg, input logic [63:0] m);
        int          p;
        logic [80:0] t;
        p = -1;
        for (int b = 0; b < 64; b++) if (m[b]) p = b;
        if (p < 0) return {neg, 95'd0};
        t = 81'(m) << (80 - p);
        return {neg, 15'(BIAS + p), t[79:0]};
    endfunction

    task automatic load_req(input int k, input bit o, input bit neg, input logic [63:0] m, input int bexp);
        logic [95:0] v;
        r_op[k] = o;
        if (bexp > 0) begin
            r_data[k] = {neg, 15'(BIAS + bexp), 80'd0};
            r_eovf[k] = 1'b1;
            r_exp[k]  = o ? (neg ? SMIN : SMAX) : '1;
        end else begin
            v         = {32'd0, m};
            r_data[k] = enc(neg, m);
            r_eovf[k] = 1'b0;
            r_exp[k]  = (o && neg) ? -v : v;
        end
    endtask

    task automatic reload(input int k);
        logic [63:0] m;
        m = {$urandom(), $urandom()} >> $urandom_range(0, 63);
        load_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(96, 300)) : 0);
    endtask

    // Scoreboard: expected responses in grant order, round-robin pointer, sticky flags
    typedef struct {
        logic [95:0] opnd;
        bit          op;
        logic [95:0] d;
        bit          ovf;
        int          id;
        int          rdy;
    } item_t;

    item_t           q[$];
    int              cyc = 0;
    int              gcyc = -100;
    int              m_last = NREQ - 1;
    logic [NREQ-1:0] m_sticky = '0;
    logic [NREQ-1:0] acc_vec = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit              exp_rv, allowed;
        int              w, win;
        logic [NREQ-1:0] exp_ready, set_v;
        item_t           it;
        if (!rst_n) begin
            q.delete();
            m_last   = NREQ - 1;
            m_sticky = '0;
            gcyc     = -100;
            acc_vec  = '0;
        end else begin
            exp_rv = (q.size() > 0) && (cyc >= q[0].rdy);
            check_eq("rsp_valid", rsp_valid, exp_rv);
            check_eq("cvt_ce", cvt_ce, cyc == gcyc + 1);
            if (q.size() > 0 && cyc < q[0].rdy) begin
                check_eq("cvt_i_held", cvt_i, q[0].opnd);
                check_eq("cvt_op_held", cvt_op, q[0].op);
            end
            allowed = (q.size() == 0) || (exp_rv && rsp_ready);
            win = -1;
            for (int i = 1; i <= NREQ; i++) begin
                w = (m_last + i) % NREQ;
                if (req_valid[w]) begin
                    win = w;
                    break;
                end
            end
            exp_ready = '0;
            if (allowed && win >= 0) exp_ready[win] = 1'b1;
            check_eq("req_ready", req_ready, exp_ready);
            check_eq("ovf_sticky", ovf_sticky, m_sticky);
            set_v = '0;
            if (exp_rv && rsp_ready) begin
                it = q.pop_front();
                check_eq("rsp_data", rsp_data, it.d);
                check_eq("rsp_ovf", rsp_ovf, it.ovf);
                check_eq("rsp_id", rsp_id, it.id);
                if (it.ovf && STICKY) set_v[it.id] = 1'b1;
            end
            if (STICKY) m_sticky = (m_sticky & ~ovf_clr) | set_v;
            acc_vec = req_valid & req_ready;
            if (exp_ready != 0) begin
                q.push_back('{r_data[win], r_op[win], r_exp[win], r_eovf[win], win, cyc + 3});
                gcyc   = cyc;
                m_last = win;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("grant_wait", req_ready[k], 1'b1);
    endtask

    task automatic wait_rsp;
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("rsp_wait", rsp_valid, 1'b1);
    endtask

    task automatic one_shot(input int k, input bit o, input bit neg, input logic [63:0] m, input int bexp,
                            input logic [NREQ-1:0] clr, output logic [95:0] d, output logic ov,
                            output logic [IDW-1:0] id);
        tick;
        load_req(k, o, neg, m, bexp);
        req_valid[k] = 1'b1;
        wait_grant(k);
        tick;
        req_valid[k] = 1'b0;
        wait_rsp;
        d  = rsp_data;
        ov = rsp_ovf;
        id = rsp_id;
        tick;
        rsp_ready = 1'b1;
        ovf_clr   = clr;
        tick;
        rsp_ready = 1'b0;
        ovf_clr   = '0;
    endtask

    logic [95:0]    d0;
    logic           ov0;
    logic [IDW-1:0] id0;
    int             gid[8];
    int             gcy[8];
    int             ng;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        ovf_clr   = '0;
        for (int k = 0; k < NREQ; k++) load_req(k, 1'b0, 1'b0, 64'd0, 0);
        repeat (3) tick;
        rst_n = 1'b1;

        @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_cvt_ce", cvt_ce, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_rsp_ovf", rsp_ovf, 0);
        check_eq("rst_cvt_i", cvt_i, 0);
        check_eq("rst_sticky", ovf_sticky, 0);

        // Requester 2 sends 3.0 signed: grant in T, ce in T+1 only, response from T+3
        tick;
        load_req(2, 1'b1, 1'b0, 64'd3, 0);
        req_valid = 4'b0100;
        @(negedge clk);
        check_eq("t1_grant", req_ready, 4'b0100);
        check_eq("t1_ce_T", cvt_ce, 0);
        tick;
        req_valid = '0;
        @(negedge clk);
        check_eq("t1_ce_T1", cvt_ce, 1);
        tick;
        @(negedge clk);
        check_eq("t1_ce_T2", cvt_ce, 0);
        check_eq("t1_rv_T2", rsp_valid, 0);
        tick;
        @(negedge clk);
        check_eq("t1_rv_T3", rsp_valid, 1);
        check_eq("t1_data", rsp_data, 96'd3);
        check_eq("t1_id", rsp_id, 2);
        check_eq("t1_ovf", rsp_ovf, 0);
        tick;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // -2.0 signed and unsigned
        one_shot(1, 1'b1, 1'b1, 64'd2, 0, '0, d0, ov0, id0);
        check_eq("neg2_signed", d0, {{94{1'b1}}, 2'b10});
        check_eq("neg2_id", id0, 1);
        one_shot(1, 1'b0, 1'b1, 64'd2, 0, '0, d0, ov0, id0);
        check_eq("neg2_unsigned", d0, 96'd2);

        // All four requesters continuously valid after reset
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) reload(k);
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            gid[i] = -1;
            gcy[i] = -1;
        end
        ng = 0;
        repeat (16) begin
            @(negedge clk);
            if (req_ready != 0 && ng < 8) begin
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) gid[ng] = k;
                gcy[ng] = cyc;
                ng++;
            end
            tick;
            for (int k = 0; k < NREQ; k++) if (acc_vec[k]) reload(k);
        end
        for (int i = 0; i < 5; i++) check_eq($sformatf("rr_order%0d", i), gid[i], i % NREQ);
        for (int i = 1; i < 5; i++) check_eq($sformatf("rr_gap%0d", i), gcy[i] - gcy[i-1], 3);
        req_valid = '0;
        repeat (6) tick;

        // Response stall for 5 cycles with others waiting
        rsp_ready = 1'b0;
        load_req(0, 1'b1, 1'b0, 64'd77, 0);
        req_valid = 4'b0001;
        wait_grant(0);
        tick;
        req_valid = '0;
        wait_rsp;
        tick;
        load_req(1, 1'b0, 1'b0, 64'd5, 0);
        load_req(2, 1'b0, 1'b0, 64'd6, 0);
        req_valid = 4'b0110;
        d0  = rsp_data;
        id0 = rsp_id;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_ready", req_ready, 0);
            check_eq("stall_ce", cvt_ce, 0);
            check_eq("stall_rv", rsp_valid, 1);
            check_eq("stall_data", rsp_data, d0);
            check_eq("stall_id", rsp_id, id0);
            if (i < 4) tick;
        end
        tick;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("stall_release", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        repeat (6) tick;
        rsp_ready = 1'b0;

        // Overflow on requester 3 and sticky behaviour
        one_shot(3, 1'b1, 1'b0, 64'd0, 200, '0, d0, ov0, id0);
        check_eq("ovf_data", d0, SMAX);
        check_eq("ovf_flag", ov0, 1);
        check_eq("ovf_id", id0, 3);
        @(negedge clk);
        check_eq("sticky_set", ovf_sticky, {STICKY, 3'b000});
        one_shot(3, 1'b1, 1'b1, 64'd0, 150, 4'b1000, d0, ov0, id0);
        check_eq("ovf_neg_data", d0, SMIN);
        @(negedge clk);
        check_eq("sticky_set_wins", ovf_sticky, {STICKY, 3'b000});
        tick;
        ovf_clr = 4'b1000;
        tick;
        ovf_clr = '0;
        @(negedge clk);
        check_eq("sticky_clr", ovf_sticky, 0);

        // Reset during CAPT aborts the conversion and restores the pointer
        tick;
        load_req(2, 1'b1, 1'b0, 64'd9, 0);
        req_valid = 4'b0100;
        wait_grant(2);
        tick;
        req_valid = '0;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        load_req(0, 1'b0, 1'b0, 64'd11, 0);
        load_req(3, 1'b0, 1'b0, 64'd12, 0);
        req_valid = 4'b1001;
        @(negedge clk);
        check_eq("abort_rv", rsp_valid, 0);
        check_eq("abort_grant0", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) tick;

        // Randomized traffic
        for (int k = 0; k < NREQ; k++) reload(k);
        repeat (2000) begin
            tick;
            for (int k = 0; k < NREQ; k++) begin
                if (acc_vec[k]) begin
                    if ($urandom_range(0, 3) != 0) reload(k);
                    else req_valid[k] = 1'b0;
                end else if (!req_valid[k]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        reload(k);
                        req_valid[k] = 1'b1;
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0) ? NREQ'($urandom()) : '0;
        end
        tick;
        req_valid = '0;
        rsp_ready = 1'b1;
        ovf_clr   = '0;
        repeat (10) tick;
        @(negedge clk);
        check_eq("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fcvt96_arbiter.md
# fcvt96_arbiter

Round-robin arbiter and sequencer that shares one single-cycle `f2i96` float-to-integer converter among `NREQ` requesters. It accepts requests over per-requester valid/ready handshakes and drives the converter's `ce`, `op` and `i` inputs. It captures `o` and `overflow` at the correct cycles and returns each result with the requester id over a single valid/ready response port. It sits between the issue logic of the FP cluster and the converter instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WID`, 96: operand/result width; must equal the converter's `FPWID`.
- `IDW`, `$clog2(NREQ)`: id width, derived.

- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  NREQ  request k pending.
- `req_ready`  out  NREQ  one-hot grant; request k accepted when `req_valid[k] & req_ready[k]`.
- `req_op`  in  NREQ  per-requester op (1 = signed, 0 = unsigned).
- `req_data`  in  NREQ*WID  per-requester fp96 operand, requester k at `[k*WID +: WID]`.
- `cvt_ce`  out  1  converter clock enable.
- `cvt_op`  out  1  converter op.
- `cvt_i`  out  WID  converter operand.
- `cvt_o`  in  WID  converter result.
- `cvt_ovf`  in  1  converter overflow (combinational from `cvt_i`).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  WID  integer result.
- `rsp_ovf`  out  1  overflow flag for this result.
- `rsp_id`  out  IDW  requester index.
- `ovf_sticky`  out  NREQ  sticky overflow per requester (see Configuration).
- `ovf_clr`  in  NREQ  clear for `ovf_sticky`.

## Operation
- Converter constraints the sequencing must honour:
  - `overflow` is combinational from `i`.
  - `o` is registered on `ce`, but its sign fix-up uses the live `op`.
  - Consequence: at most one conversion is in flight, and `cvt_op`/`cvt_i` are held from issue through capture.
- Operand register `{op_q, data_q, id_q}` drives `cvt_op`/`cvt_i` directly.
- FSM states:
  - IDLE: if any `req_valid`, the round-robin winner is granted (`req_ready` one-hot, combinational), operand register loads, next state is ISSUE. If no request is pending, stay in IDLE and all `req_ready` = 0.
  - ISSUE: `cvt_ce` = 1; latch `cvt_ovf` into `ovf_q`; next state is CAPT.
  - CAPT: `cvt_ce` = 0, operands held. Load `rsp_data` ← `cvt_o`, `rsp_ovf` ← `ovf_q`, `rsp_id` ← `id_q`. Next state is RSP.
  - RSP: `rsp_valid` = 1, outputs stable until `rsp_ready`.
    - On handshake with a request pending: grant in the same cycle and go to ISSUE.
    - On handshake with no request pending: go to IDLE.
    - Without handshake: stay in RSP, all `req_ready` = 0.
- Round robin:
  - Pointer `last` holds the most recent grant; search order is `last+1` … `last`, modulo `NREQ`.
  - `last` updates only on an actual grant.
  - A requester that drops `req_valid` before grant loses nothing; no grant is ever given to a non-valid requester.
- `cvt_ce` is asserted only in ISSUE; it is never asserted two cycles in a row.
- Reset values (`rst_n` low at a clock edge):
  - state = IDLE; `last` = NREQ-1, so requester 0 wins first.
  - `rsp_valid`, `rsp_ovf`, `rsp_id`, `rsp_data`, operand register, `ovf_q`, `ovf_sticky` = 0.
  - `cvt_ce` = 0, `req_ready` = 0.
- Reset mid-operation aborts the in-flight conversion; no response is produced for it.

## Timing
- Request accepted in cycle T: `cvt_ce` high in T+1, result sampled in T+2, `rsp_valid` high from T+3.
- Request-to-response latency is 3 cycles.
- Peak throughput is one result per 3 cycles with `rsp_ready` tied high: RSP→ISSUE overlap removes IDLE.
- `req_ready` depends combinationally on state, `req_valid`, `last` and `rsp_ready` (in RSP). It does not depend on `req_data`.
- No combinational path from `cvt_o` to any output.

## Configuration
- `FCVT96_OVF_STICKY_EN` defined:
  - On a response handshake with `rsp_ovf` = 1, `ovf_sticky[rsp_id]` sets.
  - `ovf_clr[k]` clears bit k on the next edge.
  - Set and clear of the same bit in the same cycle: set wins.
- Not defined: `ovf_sticky` is constant 0, `ovf_clr` is ignored, and no sticky flops exist.

## Test plan
- Reset, then requester 2 sends 3.0 with op=1:
  - `req_ready` = 4'b0100 in T; `cvt_ce` pulses only in T+1.
  - `rsp_valid` in T+3 with `rsp_data` = 3, `rsp_id` = 2, `rsp_ovf` = 0.
- Requester 1 sends −2.0 with op=1; `cvt_op` is held 1 through CAPT:
  - `rsp_data` = all-ones except LSB 0, i.e. −2.
  - The same operand with op=0 gives 2.
- All four requesters valid continuously, `rsp_ready` = 1:
  - Grants go 0,1,2,3,0 at 3-cycle spacing.
  - `rsp_id` follows the same order.
- `rsp_ready` held 0 for 5 cycles in RSP:
  - `rsp_*` stable, no `req_ready`, no `cvt_ce`.
  - On release, the next grant occurs in the same cycle.
- Requester 3 sends 2^200 with op=1:
  - `rsp_ovf` = 1, `rsp_data` = max signed value.
  - With the macro defined, `ovf_sticky[3]` = 1 after the handshake.
  - Simultaneous `ovf_clr[3]` with a second overflow keeps the bit set; a lone `ovf_clr[3]` clears it.
- `rst_n` low during CAPT:
  - Next cycle is IDLE with `rsp_valid` = 0.
  - The next request granted is from requester 0 if valid.
